fc_neuron_accumulator: RTL and testbench

//   Downstream stage of the fully-connected ALU. Sums the ALU's per-chunk outputs when a neuron has more

---
 rtl/fc_neuron_accumulator.sv | 123 ++++++++++++
 tb/tb_fc_neuron_accumulator.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fc_neuron_accumulator.sv
// Sums the per-chunk ALU results of one neuron, applies optional ReLU, saturates to SIZE bits,
// and hands one result per neuron downstream over a valid/ready output.
module fc_neuron_accumulator #(
  parameter int SIZE       = 16,
  parameter int PRECISION  = 11,
  parameter int MAX_CHUNKS = 64,
  parameter int RELU_EN    = 1,
  localparam int CW        = $clog2(MAX_CHUNKS + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [CW-1:0]   i_num_chunks,
  input  logic            i_valid,
  input  logic [SIZE-1:0] i_value,
  output logic            o_busy,
  output logic [CW-1:0]   o_chunk_idx,
  output logic            o_valid,
  output logic [SIZE-1:0] o_value,
  input  logic            i_ready,
  output logic [1:0]      dbg_state
);

  localparam int ACC_W = SIZE + CW;

  // The binary point only matters to the producer; reject formats that cannot exist.
  if (PRECISION >= SIZE || MAX_CHUNKS < 1) begin : g_bad_params
    $error("fc_neuron_accumulator: invalid SIZE/PRECISION/MAX_CHUNKS");
  end

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'd1 << (SIZE - 1)) - 64'd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_OUTPUT = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] r;
  logic [CW-1:0]           cnt;
  logic [CW-1:0]           n_chunks;
  logic [SIZE-1:0]         final_val;
  logic                    start_ok;
  logic                    last_chunk;

  assign start_ok   = i_start && (i_num_chunks != '0);
  assign last_chunk = (cnt == n_chunks - CW'(1));
  assign sum        = acc + {{CW{i_value[SIZE-1]}}, i_value};

  // Handshake: o_value is transferred on a posedge where o_valid && i_ready; while o_valid is
  // high and i_ready is low, o_valid and o_value hold. i_valid has no back-pressure: a chunk is
  // taken on any posedge in ACCUM with i_valid high.

  always_comb begin
    r = sum;
    if (RELU_EN != 0 && r[ACC_W-1]) r = '0;
    if (r > SAT_MAX)      final_val = {1'b0, {(SIZE-1){1'b1}}};
    else if (r < SAT_MIN) final_val = {1'b1, {(SIZE-1){1'b0}}};
    else                  final_val = r[SIZE-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (start_ok)              state_nxt = S_ACCUM;
      S_ACCUM:  if (i_valid && last_chunk) state_nxt = S_OUTPUT;
      S_OUTPUT: if (i_ready)               state_nxt = S_IDLE;
      default:                             state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      cnt      <= '0;
      n_chunks <= '0;
      o_value  <= '0;
      o_valid  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start_ok) begin
            n_chunks <= i_num_chunks;
            acc      <= '0;
            cnt      <= '0;
          end
        end
        S_ACCUM: begin
          if (i_valid) begin
            acc <= sum;
            cnt <= cnt + CW'(1);
            if (last_chunk) begin
              o_value <= final_val;
              o_valid <= 1'b1;
            end
          end
        end
        S_OUTPUT: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            cnt     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy      = (state == S_ACCUM) || (state == S_OUTPUT);
  assign o_chunk_idx = cnt;
  assign dbg_state   = state;

endmodule

// File: tb/tb_fc_neuron_accumulator.sv
// Directed bench: two instances (ReLU on / off) share stimulus; table of neurons plus hand sequences.
module tb_fc_neuron_accumulator;

  localparam int SIZE       = 16;
  localparam int MAX_CHUNKS = 64;
  localparam int CW         = $clog2(MAX_CHUNKS + 1);
  localparam int NV         = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_start;
  logic [CW-1:0]   i_num_chunks;
  logic            i_valid;
  logic [SIZE-1:0] i_value;
  logic            i_ready;

  logic            busy_r, valid_r, busy_l, valid_l;
  logic [CW-1:0]   idx_r, idx_l;
  logic [SIZE-1:0] value_r, value_l;
  logic [1:0]      st_r, st_l;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fc_neuron_accumulator #(.SIZE(SIZE), .PRECISION(11), .MAX_CHUNKS(MAX_CHUNKS), .RELU_EN(1)) dut_relu (
    .clk(clk), .rst(rst), .i_start(i_start), .i_num_chunks(i_num_chunks),
    .i_valid(i_valid), .i_value(i_value), .o_busy(busy_r), .o_chunk_idx(idx_r),
    .o_valid(valid_r), .o_value(value_r), .i_ready(i_ready), .dbg_state(st_r)
  );

  fc_neuron_accumulator #(.SIZE(SIZE), .PRECISION(11), .MAX_CHUNKS(MAX_CHUNKS), .RELU_EN(0)) dut_lin (
    .clk(clk), .rst(rst), .i_start(i_start), .i_num_chunks(i_num_chunks),
    .i_valid(i_valid), .i_value(i_value), .o_busy(busy_l), .o_chunk_idx(idx_l),
    .o_valid(valid_l), .o_value(value_l), .i_ready(i_ready), .dbg_state(st_l)
  );

  typedef struct {
    int          n;
    logic [15:0] v[4];
    int          gaps;
    logic [15:0] exp_relu;
    logic [15:0] exp_lin;
    string       name;
  } vec_t;

  vec_t tbl[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int k, input int n, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d, input int g,
                         input logic [15:0] er, input logic [15:0] el, input string nm);
    tbl[k].n = n;
    tbl[k].v[0] = a; tbl[k].v[1] = b; tbl[k].v[2] = c; tbl[k].v[3] = d;
    tbl[k].gaps = g;
    tbl[k].exp_relu = er;
    tbl[k].exp_lin = el;
    tbl[k].name = nm;
  endtask

  task automatic check_idle(input string nm);
    check({nm, "_state_r"}, 32'(st_r), 32'd0);
    check({nm, "_state_l"}, 32'(st_l), 32'd0);
    check({nm, "_busy"}, 32'(busy_r), 32'd0);
    check({nm, "_valid"}, 32'(valid_r), 32'd0);
    check({nm, "_idx"}, 32'(idx_r), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_vec(0, 1, 16'h0800, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0800, 16'h0800, "t1_single");
    set_vec(1, 3, 16'h0800, 16'h0400, 16'hFC00, 16'h0000, 1, 16'h0800, 16'h0800, "t2_stalls");
    set_vec(2, 2, 16'hF800, 16'hFC00, 16'h0000, 16'h0000, 0, 16'h0000, 16'hF400, "t3_relu");
    set_vec(3, 4, 16'h7000, 16'h7000, 16'h7000, 16'h7000, 0, 16'h7FFF, 16'h7FFF, "t4_satpos");
    set_vec(4, 4, 16'h9000, 16'h9000, 16'h9000, 16'h9000, 2, 16'h0000, 16'h8000, "t4_satneg");
    set_vec(5, 2, 16'h7FFF, 16'h0001, 16'h0000, 16'h0000, 0, 16'h7FFF, 16'h7FFF, "max_plus1");
    set_vec(6, 2, 16'h8000, 16'hFFFF, 16'h0000, 16'h0000, 0, 16'h0000, 16'h8000, "min_minus1");
    set_vec(7, 2, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 1, 16'h0000, 16'h8000, "min_exact");
    set_vec(8, 1, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 0, 16'h7FFF, 16'h7FFF, "max_exact");
    set_vec(9, 4, 16'h4000, 16'hC000, 16'h0123, 16'hFEDD, 0, 16'h0000, 16'h0000, "cancel");

    rst = 1'b1; i_start = 1'b0; i_num_chunks = '0; i_valid = 1'b0; i_value = '0; i_ready = 1'b0;
    tick(); tick();
    check_idle("reset");
    check("reset_value", 32'(value_r), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < NV; i++) begin
      i_start = 1'b1; i_num_chunks = CW'(tbl[i].n);
      tick();
      i_start = 1'b0;
      check({tbl[i].name, "_busy"}, 32'(busy_r), 32'd1);
      for (int j = 0; j < tbl[i].n; j++) begin
        for (int g = 0; g < tbl[i].gaps; g++) tick();
        check({tbl[i].name, "_idx"}, 32'(idx_r), 32'(j));
        check({tbl[i].name, "_early_valid"}, 32'(valid_r), 32'd0);
        i_valid = 1'b1; i_value = tbl[i].v[j];
        tick();
        i_valid = 1'b0;
      end
      check({tbl[i].name, "_valid_r"}, 32'(valid_r), 32'd1);
      check({tbl[i].name, "_valid_l"}, 32'(valid_l), 32'd1);
      check({tbl[i].name, "_value_r"}, 32'(value_r), 32'(tbl[i].exp_relu));
      check({tbl[i].name, "_value_l"}, 32'(value_l), 32'(tbl[i].exp_lin));
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      check_idle({tbl[i].name, "_done"});
    end

    // Zero-length request must be ignored.
    i_start = 1'b1; i_num_chunks = '0;
    tick();
    i_start = 1'b0;
    check_idle("n_zero");

    // A chunk presented alongside the start must not be accumulated.
    i_start = 1'b1; i_num_chunks = CW'(1); i_valid = 1'b1; i_value = 16'h1000;
    tick();
    i_start = 1'b0;
    check("start_valid_idx", 32'(idx_r), 32'd0);
    check("start_valid_pending", 32'(valid_r), 32'd0);
    i_value = 16'h0100;
    tick();
    i_valid = 1'b0;
    check("start_valid_value", 32'(value_r), 32'h0100);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;

    // Back-pressure: output holds while start/valid pulses are ignored.
    i_start = 1'b1; i_num_chunks = CW'(2);
    tick();
    i_start = 1'b0;
    i_valid = 1'b1; i_value = 16'h0300; tick();
    i_value = 16'h0200; tick();
    i_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      i_start = (k % 2 == 0); i_num_chunks = CW'(1);
      i_valid = (k % 2 == 1); i_value = 16'h7000;
      tick();
      check("bp_valid", 32'(valid_r), 32'd1);
      check("bp_value", 32'(value_r), 32'h0500);
      check("bp_state", 32'(st_r), 32'd2);
    end
    i_valid = 1'b0;
    i_start = 1'b1; i_ready = 1'b1;
    tick();
    i_start = 1'b0; i_ready = 1'b0;
    check_idle("bp_release");

    // Reset in the middle of a neuron, then a clean neuron.
    i_start = 1'b1; i_num_chunks = CW'(4);
    tick();
    i_start = 1'b0;
    i_valid = 1'b1; i_value = 16'h2000; tick(); tick();
    check("mid_idx", 32'(idx_r), 32'd2);
    i_valid = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; i_valid = 1'b0;
    check_idle("mid_reset");
    check("mid_reset_value", 32'(value_l), 32'd0);
    i_start = 1'b1; i_num_chunks = CW'(1);
    tick();
    i_start = 1'b0;
    i_valid = 1'b1; i_value = 16'h0100;
    tick();
    i_valid = 1'b0;
    check("post_reset_valid", 32'(valid_r), 32'd1);
    check("post_reset_value_r", 32'(value_r), 32'h0100);
    check("post_reset_value_l", 32'(value_l), 32'h0100);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    check_idle("post_reset_done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
